door_plant_model: RTL
=====================

Name: door_plant_model

Overview:
Synthesizable emulator of the garage-door mechanism that sits on the far side of the door controller's motor/limit-switch interface. It consumes the UP_motor/DN_motor drive commands, tracks door position with a step counter, and produces the UP_MAX/DN_MAX limit-switch signals the controller reads. It is used for closed-loop simulation and for FPGA demos without a physical door.

Parameters:
POS_W, 8, width of position counter
TRAVEL, 200, position value at fully open (closed = 0); must be < 2**POS_W and >= 1
STEP_DIV, 4, clocks per position step while a motor is driven; >= 1
INIT_POS, 0, position loaded on reset; 0..TRAVEL

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
UP_motor  in  1  raise command from controller
DN_motor  in  1  lower command from controller
UP_MAX  out  1  high when position == TRAVEL (fully open)
DN_MAX  out  1  high when position == 0 (fully closed)
position  out  POS_W  current door position
moving  out  1  high while in RAISING or LOWERING
overdrive  out  1  motor driven into the limit it has already reached
fault  out  1  sticky; both motor commands seen high together

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: position=INIT_POS, prescaler=0, state=IDLE, moving=0, overdrive=0, fault=0. UP_MAX/DN_MAX follow the INIT_POS decode.
- UP_MAX and DN_MAX are decoded directly from the position register. No added latency.
- States: IDLE, RAISING, LOWERING, FAULT. Each transition is evaluated at the clock edge from the sampled inputs:
  - any state except FAULT, UP_motor=1 and DN_motor=1 -> FAULT
  - FAULT -> FAULT until reset. Position is frozen, moving=0, fault=1.
  - UP only -> RAISING; DN only -> LOWERING; neither -> IDLE.
- Prescaler:
  - Counts 0..STEP_DIV-1 while in RAISING or LOWERING.
  - Cleared on entry to IDLE, on entry to FAULT, and on any direction change.
  - On an edge where the prescaler equals STEP_DIV-1, it wraps to 0 and a step is issued.
  - STEP_DIV=1 means one step per clock.
- Step:
  - RAISING: position+1, saturating at TRAVEL.
  - LOWERING: position-1, saturating at 0.
  - Position never wraps.
- overdrive:
  - Registered. Set on the edge where state is RAISING with position==TRAVEL, or LOWERING with position==0.
  - Cleared when that condition no longer holds.
  - Moving at a limit does not step; the prescaler keeps counting harmlessly.
- moving=1 in RAISING or LOWERING, including while overdriving.
- Reset asserted mid-travel returns all registers to their reset values immediately, without waiting for a clock.

Optional Feature:
Macro DOOR_OBSTRUCT_EN.
- Defined:
  - Adds input obstruct (1 bit) and output obstructed (1 bit, reset 0).
  - While in LOWERING with obstruct=1: no step is issued, the prescaler is held, and obstructed=1 (registered).
  - RAISING is unaffected by obstruct.
  - obstructed clears on the first edge on which obstruct=0 or the state is not LOWERING.
- Not defined: neither port exists, and LOWERING is never inhibited.

Test Plan:
All scenarios use TRAVEL=8, STEP_DIV=2, INIT_POS=0.
1. Reset: hold RST=0 -> position=0, DN_MAX=1, UP_MAX=0, moving=0, overdrive=0, fault=0.
2. Full open: release reset, UP_motor=1 for 16 clocks -> position increments every 2nd edge, DN_MAX falls after the 2nd edge, position=8 and UP_MAX=1 after the 16th edge.
3. Overdrive at top: keep UP_motor=1 for 5 more clocks -> position stays 8, overdrive=1 from the 1st extra edge. Drop UP_motor -> overdrive=0, moving=0 next edge.
4. Reversal mid-travel: at position 4 with prescaler=1, switch to DN_motor=1 -> prescaler cleared, position=3 after 2 edges, not 1.
5. Fault: UP_motor=DN_motor=1 for one clock at position 3 -> fault=1, moving=0, position held at 3. After commands drop, fault stays 1 until RST=0.
6. Async reset mid-travel: at position 5 while raising, pulse RST=0 between clock edges -> position=0, DN_MAX=1 immediately, before the next edge.
7. With DOOR_OBSTRUCT_EN: lowering from position 6, obstruct=1 for 6 clocks -> position stays 6, obstructed=1. Release obstruct -> position=5 after 2 edges.

Source files
------------

// File: rtl/door_plant_model.sv
// Garage-door mechanism emulator: turns UP_motor/DN_motor commands into a stepped position and limit switches.
// Optional obstruction sensing on the downward stroke is enabled by defining DOOR_OBSTRUCT_EN.
module door_plant_model #(
    parameter int POS_W    = 8,
    parameter int TRAVEL   = 200,
    parameter int STEP_DIV = 4,
    parameter int INIT_POS = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UP_motor,
    input  logic             DN_motor,
`ifdef DOOR_OBSTRUCT_EN
    input  logic             obstruct,
    output logic             obstructed,
`endif
    output logic             UP_MAX,
    output logic             DN_MAX,
    output logic [POS_W-1:0] position,
    output logic             moving,
    output logic             overdrive,
    output logic             fault
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]    PRE_MAX  = PW'(STEP_DIV - 1);
    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(TRAVEL);
    localparam logic [POS_W-1:0] POS_INIT = POS_W'(INIT_POS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAISING  = 2'd1,
        LOWERING = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             od_q, od_d;
    logic             hold;
    logic             dir_change;
    logic             step;
    logic [PW-1:0]    pre_eff;

`ifdef DOOR_OBSTRUCT_EN
    logic obs_q, obs_d;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            pre_q   <= '0;
            pos_q   <= POS_INIT;
            od_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            pos_q   <= pos_d;
            od_q    <= od_d;
        end
    end

`ifdef DOOR_OBSTRUCT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) obs_q <= 1'b0;
        else      obs_q <= obs_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        if (state_q != FAULT) begin
            if (UP_motor && DN_motor) state_d = FAULT;
            else if (UP_motor)        state_d = RAISING;
            else if (DN_motor)        state_d = LOWERING;
            else                      state_d = IDLE;
        end
    end

    always_comb begin
        dir_change = ((state_q == RAISING) && (state_d == LOWERING)) ||
                     ((state_q == LOWERING) && (state_d == RAISING));
`ifdef DOOR_OBSTRUCT_EN
        hold  = (state_d == LOWERING) && obstruct;
        obs_d = hold;
`else
        hold  = 1'b0;
`endif
        // A reversal restarts the count from zero on the same edge, so the
        // first step in the new direction lands STEP_DIV edges later.
        pre_eff = dir_change ? '0 : pre_q;
        pre_d   = '0;
        step    = 1'b0;
        if ((state_d == RAISING) || (state_d == LOWERING)) begin
            if (hold) begin
                pre_d = pre_eff;
            end else if (pre_eff == PRE_MAX) begin
                pre_d = '0;
                step  = 1'b1;
            end else begin
                pre_d = pre_eff + 1'b1;
            end
        end

        pos_d = pos_q;
        if (step) begin
            if ((state_d == RAISING) && (pos_q != POS_TOP))
                pos_d = pos_q + 1'b1;
            else if ((state_d == LOWERING) && (pos_q != '0))
                pos_d = pos_q - 1'b1;
        end

        od_d = ((state_d == RAISING) && (pos_q == POS_TOP)) ||
               ((state_d == LOWERING) && (pos_q == '0));
    end

    assign position  = pos_q;
    assign UP_MAX    = (pos_q == POS_TOP);
    assign DN_MAX    = (pos_q == '0);
    assign moving    = (state_q == RAISING) || (state_q == LOWERING);
    assign overdrive = od_q;
    assign fault     = (state_q == FAULT);
`ifdef DOOR_OBSTRUCT_EN
    assign obstructed = obs_q;
`endif

endmodule
